capp_search_ctrl: RTL and testbench

- Controller that sequences the content-addressable parallel processor (CAPP) datapath: comparand register, mask register, a WORDS-deep word array and a per-word tag (responder) register.
- Accepts one command at a time over a valid/ready interface.
- Runs searches and masked multi-writes by scanning the array with a single shared comparator, one word per cycle.
- Returns a one-cycle response carrying hit, responder count and read data.

---
 rtl/capp_search_ctrl.sv | 155 +++++++++++++++
 tb/tb_capp_search_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/capp_search_ctrl.sv
// Sequencer for a CAPP datapath. It holds the comparand, mask, word array and tag register,
// and scans the array one word per cycle through a single shared comparator.
module capp_search_ctrl #(
  parameter int WIDTH = 32,
  parameter int WORDS = 8,
  parameter int AW    = $clog2(WORDS),
  parameter int CW    = $clog2(WORDS + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [CW-1:0]    rsp_count,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WORDS-1:0] tags
);

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_LOAD_CMP     = 3'd1;
  localparam logic [2:0] OP_LOAD_MSK     = 3'd2;
  localparam logic [2:0] OP_WRITE        = 3'd3;
  localparam logic [2:0] OP_SEARCH       = 3'd4;
  localparam logic [2:0] OP_MULTI_WRITE  = 3'd5;
  localparam logic [2:0] OP_SELECT_FIRST = 3'd6;
  localparam logic [2:0] OP_READ_FIRST   = 3'd7;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cmp_reg, msk_reg;
  logic [WIDTH-1:0] word_reg [WORDS];
  logic [WORDS-1:0] tag_reg, tag_next;
  logic [AW-1:0]    idx_reg;
  logic             mw_reg;
  logic             rsp_hit_reg;
  logic [CW-1:0]    rsp_count_reg;
  logic [WIDTH-1:0] rsp_data_reg;

  logic             accept, scan_last, word_match, read_first;
  logic [WORDS-1:0] first_oh;
  logic [WIDTH-1:0] word_sel [WORDS];
  logic [WIDTH-1:0] first_word;
  logic [CW-1:0]    count_next;

  assign accept     = cmd_valid && (state_reg == IDLE);
  assign read_first = accept && (cmd_op == OP_READ_FIRST);
  assign scan_last  = (idx_reg == AW'(WORDS - 1));
  assign word_match = (((word_reg[idx_reg] ^ cmp_reg) & msk_reg) == '0);
  // Two's-complement trick isolates the lowest set tag; zero tags stay zero.
  assign first_oh   = tag_reg & (~tag_reg + WORDS'(1));

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_sel
      assign word_sel[gi] = word_reg[gi] & {WIDTH{first_oh[gi]}};
    end
  endgenerate

  always_comb begin
    first_word = '0;
    for (int i = 0; i < WORDS; i++) first_word = first_word | word_sel[i];
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (cmd_valid)
              state_next = (cmd_op == OP_SEARCH || cmd_op == OP_MULTI_WRITE) ? SCAN : DONE;
      SCAN: if (scan_last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    rsp_valid = (state_reg == DONE);
    rsp_hit   = rsp_hit_reg;
    rsp_count = rsp_count_reg;
    rsp_data  = rsp_data_reg;
    tags      = tag_reg;
  end

  always_comb begin
    tag_next = tag_reg;
    if (accept && cmd_op == OP_SELECT_FIRST) tag_next = first_oh;
    else if (state_reg == SCAN && !mw_reg)   tag_next[idx_reg] = word_match;
  end

  // Count the tags as they will be after this edge so the response reflects the finished op.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < WORDS; i++) count_next = count_next + CW'(tag_next[i]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmp_reg <= '0;
      msk_reg <= '1;
      tag_reg <= '0;
      idx_reg <= '0;
      mw_reg  <= 1'b0;
      for (int i = 0; i < WORDS; i++) word_reg[i] <= '0;
    end else begin
      tag_reg <= tag_next;
      if (accept) begin
        case (cmd_op)
          OP_LOAD_CMP: cmp_reg <= cmd_data;
          OP_LOAD_MSK: msk_reg <= cmd_data;
          OP_WRITE:    word_reg[cmd_addr] <= cmd_data;
          default:     ;
        endcase
        idx_reg <= '0;
        mw_reg  <= (cmd_op == OP_MULTI_WRITE);
      end else if (state_reg == SCAN) begin
        if (mw_reg && tag_reg[idx_reg])
          word_reg[idx_reg] <= (word_reg[idx_reg] & ~msk_reg) | (cmp_reg & msk_reg);
        idx_reg <= scan_last ? '0 : idx_reg + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_hit_reg   <= 1'b0;
      rsp_count_reg <= '0;
      rsp_data_reg  <= '0;
    end else if (state_next == DONE) begin
      rsp_count_reg <= count_next;
      if (read_first) begin
        rsp_hit_reg  <= |tag_reg;
        rsp_data_reg <= first_word;
      end else begin
        rsp_hit_reg  <= (count_next != '0);
        rsp_data_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_capp_search_ctrl.sv
// Directed bench for capp_search_ctrl: reset, search, select, multi-write, read and handshake pacing.
module tb_capp_search_ctrl;
  localparam int WIDTH = 32;
  localparam int WORDS = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  localparam logic [2:0] NOP = 3'd0, LCMP = 3'd1, LMSK = 3'd2, WR = 3'd3;
  localparam logic [2:0] SRCH = 3'd4, MW = 3'd5, SEL = 3'd6, RD = 3'd7;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_data;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [CW-1:0]    rsp_count;
  logic [WIDTH-1:0] rsp_data;
  logic [WORDS-1:0] tags;

  int checks = 0;
  int errors = 0;
  int lat, rdy;

  capp_search_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_count(rsp_count),
    .rsp_data(rsp_data), .tags(tags)
  );

  always #5 CLK = ~CLK;

  // Issues one command and waits (bounded) for its response; lat = -1 if none arrives.
  task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [WIDTH-1:0] data, output int l, output int r);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    l = -1; r = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (cmd_ready) r++;
      if (rsp_valid) begin l = n; break; end
    end
    $display("cmd op=%0d addr=%0d data=%h lat=%0d tags=%h count=%0d hit=%b rdata=%h",
             op, addr, data, l, tags, rsp_count, rsp_hit, rsp_data);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_addr = '0; cmd_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (tags !== 8'h00) begin errors++; $display("FAIL reset_tags: got %h expected 00", tags); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rsp_count); end
  endtask

  task automatic test_reset_mid_scan();
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'hFF) begin errors++; $display("FAIL pre_search_tags: got %h expected ff", tags); end
    checks++; if (rsp_count !== 4'd8) begin errors++; $display("FAIL pre_search_count: got %0d expected 8", rsp_count); end
    do_cmd(LCMP, 0, 32'h5, lat, rdy);
    do_cmd(WR, 0, 32'h7, lat, rdy);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = SRCH;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (tags !== 8'hF8) begin errors++; $display("FAIL midscan_tags: got %h expected f8", tags); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy: got %b expected 1", busy); end
    RST_N = 1'b0;
    #1;
    checks++; if (tags !== 8'h00) begin errors++; $display("FAIL async_rst_tags: got %h expected 00", tags); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL async_rst_state: got busy=%b ready=%b expected busy=0 ready=1", busy, cmd_ready); end
    checks++; if (rsp_count !== 4'd0 || rsp_hit !== 1'b0) begin errors++; $display("FAIL async_rst_rsp: got count=%0d hit=%b expected 0 0", rsp_count, rsp_hit); end
    @(negedge CLK);
    RST_N = 1'b1;
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'hFF) begin errors++; $display("FAIL post_rst_tags: got %h expected ff", tags); end
    checks++; if (rsp_count !== 4'd8) begin errors++; $display("FAIL post_rst_count: got %0d expected 8", rsp_count); end
  endtask

  task automatic test_search();
    do_cmd(WR, 2, 32'hDEADBEEF, lat, rdy);
    checks++; if (lat !== 1) begin errors++; $display("FAIL write_latency: got %0d expected 1", lat); end
    do_cmd(WR, 5, 32'hDEADBEEF, lat, rdy);
    do_cmd(LCMP, 0, 32'hDEADBEEF, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (lat !== 9) begin errors++; $display("FAIL search_latency: got %0d expected 9", lat); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL search_ready_low: got %0d ready cycles expected 0", rdy); end
    checks++; if (tags !== 8'h24) begin errors++; $display("FAIL search_tags: got %h expected 24", tags); end
    checks++; if (rsp_count !== 4'd2) begin errors++; $display("FAIL search_count: got %0d expected 2", rsp_count); end
    checks++; if (rsp_hit !== 1'b1) begin errors++; $display("FAIL search_hit: got %b expected 1", rsp_hit); end
  endtask

  task automatic test_select();
    do_cmd(WR, 1, 32'h1234BEEF, lat, rdy);
    do_cmd(LMSK, 0, 32'h0000FFFF, lat, rdy);
    do_cmd(LCMP, 0, 32'h0000BEEF, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h26) begin errors++; $display("FAIL masked_search_tags: got %h expected 26", tags); end
    checks++; if (rsp_count !== 4'd3) begin errors++; $display("FAIL masked_search_count: got %0d expected 3", rsp_count); end
    do_cmd(SEL, 0, 0, lat, rdy);
    checks++; if (lat !== 1) begin errors++; $display("FAIL select_latency: got %0d expected 1", lat); end
    checks++; if (tags !== 8'h02) begin errors++; $display("FAIL select_tags: got %h expected 02", tags); end
    checks++; if (rsp_count !== 4'd1 || rsp_hit !== 1'b1) begin errors++; $display("FAIL select_rsp: got count=%0d hit=%b expected 1 1", rsp_count, rsp_hit); end
  endtask

  task automatic test_multi_write();
    do_cmd(LMSK, 0, 32'hFF000000, lat, rdy);
    do_cmd(LCMP, 0, 32'hAB000000, lat, rdy);
    do_cmd(MW, 0, 0, lat, rdy);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mw_latency: got %0d expected 9", lat); end
    checks++; if (tags !== 8'h02) begin errors++; $display("FAIL mw_tags: got %h expected 02", tags); end
    do_cmd(RD, 0, 0, lat, rdy);
    checks++; if (rsp_data !== 32'hAB34BEEF) begin errors++; $display("FAIL read_first_data: got %h expected ab34beef", rsp_data); end
    checks++; if (rsp_hit !== 1'b1) begin errors++; $display("FAIL read_first_hit: got %b expected 1", rsp_hit); end
    do_cmd(LMSK, 0, 32'hFFFFFFFF, lat, rdy);
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL non_read_data: got %h expected 0", rsp_data); end
    do_cmd(LCMP, 0, 32'hDEADBEEF, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h24) begin errors++; $display("FAIL mw_others_intact: got %h expected 24", tags); end
  endtask

  task automatic test_no_match();
    do_cmd(LCMP, 0, 32'h12345678, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h00) begin errors++; $display("FAIL nomatch_tags: got %h expected 00", tags); end
    checks++; if (rsp_hit !== 1'b0 || rsp_count !== 4'd0) begin errors++; $display("FAIL nomatch_rsp: got hit=%b count=%0d expected 0 0", rsp_hit, rsp_count); end
    do_cmd(RD, 0, 0, lat, rdy);
    checks++; if (rsp_data !== 32'h0 || rsp_hit !== 1'b0) begin errors++; $display("FAIL nomatch_read: got data=%h hit=%b expected 0 0", rsp_data, rsp_hit); end
    do_cmd(SEL, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h00) begin errors++; $display("FAIL select_empty: got %h expected 00", tags); end
    do_cmd(MW, 0, 0, lat, rdy);
    do_cmd(LCMP, 0, 32'hAB34BEEF, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h02) begin errors++; $display("FAIL mw_no_tags_intact: got %h expected 02", tags); end
  endtask

  task automatic test_mask_zero();
    do_cmd(LMSK, 0, 32'h0, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'hFF || rsp_count !== 4'd8) begin errors++; $display("FAIL mask_zero: got tags=%h count=%0d expected ff 8", tags, rsp_count); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3];
    ops[0] = LCMP; ops[1] = WR; ops[2] = NOP;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = ops[0]; cmd_addr = 3'd3; cmd_data = 32'h0F0F0F0F;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cmd_ready); end
      @(posedge CLK); @(negedge CLK);
      checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_%0d: got valid=%b ready=%b expected 1 0", i, rsp_valid, cmd_ready); end
      if (i < 2) cmd_op = ops[i + 1];
      else cmd_valid = 1'b0;
      @(posedge CLK); @(negedge CLK);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_not_accepted_%0d: got valid=%b expected 0", i, rsp_valid); end
      $display("b2b op=%0d ready=%b busy=%b", ops[i], cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    do_cmd(LMSK, 0, 32'hFFFFFFFF, lat, rdy);
    do_cmd(SRCH, 0, 0, lat, rdy);
    checks++; if (tags !== 8'h08) begin errors++; $display("FAIL b2b_effect: got %h expected 08", tags); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_scan();
    test_search();
    test_select();
    test_multi_write();
    test_no_match();
    test_mask_zero();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
